// File: rtl/nonogram_pkg.sv
// +----------------------------------------------------------------------------+
// | nonogram_pkg : shared sizes, scheduler state type and line helpers         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package nonogram_pkg;

  localparam int MAX_DIM    = 11;
  localparam int LINE_IDX_W = 5;
  localparam int CELL_CNT_W = 7;
  localparam int DIM_W      = 4;
  localparam int NUM_LINES  = 2 * MAX_DIM;

  localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    DISPATCH = 3'd2,
    WAIT     = 3'd3,
    FINISH   = 3'd4
  } sched_state_t;

  // Rows occupy indices 0..n-1, columns follow from n upward.
  function automatic logic line_is_row(input logic [LINE_IDX_W-1:0] idx,
                                       input logic [DIM_W-1:0]      n);
    return idx < LINE_IDX_W'(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_dirty_picker.sv
// +----------------------------------------------------------------------------+
// | rr_dirty_picker : first dirty line at or after ptr, wrapping at len        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_dirty_picker
  import nonogram_pkg::*;
(
  input  logic [NUM_LINES-1:0]  dirty_i,
  input  logic [LINE_IDX_W-1:0] ptr_i,
  input  logic [LINE_IDX_W-1:0] len_i,
  output logic                  found_o,
  output logic [LINE_IDX_W-1:0] idx_o
);

  localparam int PAD_W = 2 ** LINE_IDX_W;

  logic [PAD_W-1:0]      w_dirty_pad;
  logic [LINE_IDX_W:0]   w_cand;

  assign w_dirty_pad = {{(PAD_W - NUM_LINES){1'b0}}, dirty_i};

  // Walk offsets 0..len-1 from ptr; the first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      w_cand = {1'b0, ptr_i} + (LINE_IDX_W + 1)'(i);
      if (w_cand >= {1'b0, len_i}) begin
        w_cand = w_cand - {1'b0, len_i};
      end
      if (!found_o && ((LINE_IDX_W + 1)'(i) < {1'b0, len_i}) &&
          w_dirty_pad[w_cand[LINE_IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = w_cand[LINE_IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_scheduler.sv
// +----------------------------------------------------------------------------+
// | line_scheduler : round-robin dirty-line dispatcher for the nonogram solver |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module line_scheduler
  import nonogram_pkg::*;
(
  input  logic                  clk_100mhz,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DIM_W-1:0]      n_i,
  input  logic [DIM_W-1:0]      m_i,
  output logic                  dispatch_valid_o,
  input  logic                  dispatch_ready_i,
  output logic [LINE_IDX_W-1:0] dispatch_idx_o,
  input  logic                  result_valid_i,
  input  logic [MAX_DIM-1:0]    result_new_mask_i,
  input  logic                  result_conflict_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  solved_o,
  output logic                  error_o,
  output logic [15:0]           pass_count_o
);

  sched_state_t              state_q, state_d;
  logic [NUM_LINES-1:0]      dirty_q, dirty_d;
  logic [LINE_IDX_W-1:0]     ptr_q, ptr_d;
  logic [LINE_IDX_W-1:0]     cur_q, cur_d;
  logic [CELL_CNT_W-1:0]     known_q, known_d;
  logic [15:0]               pass_q, pass_d;
  logic [DIM_W-1:0]          n_q, n_d;
  logic [DIM_W-1:0]          m_q, m_d;
  logic                      solved_q, solved_d;
  logic                      error_q, error_d;
  logic                      done_q, done_d;

  logic [LINE_IDX_W-1:0]     w_len;
  logic [LINE_IDX_W-1:0]     w_start_len;
  logic [LINE_IDX_W-1:0]     w_cur_inc;
  logic [7:0]                w_nm;
  logic                      w_dims_bad;
  logic                      w_cur_is_row;
  logic                      w_found;
  logic [LINE_IDX_W-1:0]     w_pick_idx;
  logic [3:0]                w_row_cnt;
  logic [CELL_CNT_W:0]       w_known_sum;

  assign w_len        = LINE_IDX_W'(n_q) + LINE_IDX_W'(m_q);
  assign w_start_len  = LINE_IDX_W'(n_i) + LINE_IDX_W'(m_i);
  assign w_cur_inc    = cur_q + LINE_IDX_W'(1);
  assign w_nm         = 8'(n_q) * 8'(m_q);
  assign w_cur_is_row = line_is_row(cur_q, n_q);
  assign w_dims_bad   = (n_i == '0) || (m_i == '0) ||
                        (n_i > MAX_DIM_V) || (m_i > MAX_DIM_V);

  rr_dirty_picker u_picker (
    .dirty_i (dirty_q),
    .ptr_i   (ptr_q),
    .len_i   (w_len),
    .found_o (w_found),
    .idx_o   (w_pick_idx)
  );

  assign busy_o           = (state_q != IDLE);
  assign dispatch_valid_o = (state_q == DISPATCH);
  assign dispatch_idx_o   = cur_q;
  assign done_o           = done_q;
  assign solved_o         = solved_q;
  assign error_o          = error_q;
  assign pass_count_o     = pass_q;

  always_comb begin
    state_d     = state_q;
    dirty_d     = dirty_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    known_d     = known_q;
    pass_d      = pass_q;
    n_d         = n_q;
    m_d         = m_q;
    solved_d    = solved_q;
    error_d     = error_q;
    done_d      = 1'b0;
    w_row_cnt   = '0;
    w_known_sum = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d      = n_i;
          m_d      = m_i;
          pass_d   = '0;
          ptr_d    = '0;
          known_d  = '0;
          solved_d = 1'b0;
          if (w_dims_bad) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            dirty_d = '0;
          end else begin
            error_d = 1'b0;
            state_d = SCAN;
            for (int i = 0; i < NUM_LINES; i++) begin
              dirty_d[i] = (LINE_IDX_W'(i) < w_start_len);
            end
          end
        end
      end

      SCAN: begin
        if (w_found) begin
          cur_d   = w_pick_idx;
          state_d = DISPATCH;
        end else begin
          state_d = FINISH;
        end
      end

      DISPATCH: begin
        if (dispatch_ready_i) begin
          dirty_d[cur_q] = 1'b0;
          if (pass_q != 16'hFFFF) begin
            pass_d = pass_q + 16'd1;
          end
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (result_valid_i) begin
          if (result_conflict_i) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else begin
            // Only row results are counted so each cell contributes once.
            for (int k = 0; k < MAX_DIM; k++) begin
              if (result_new_mask_i[k]) begin
                if (w_cur_is_row) begin
                  if (DIM_W'(k) < m_q) begin
                    dirty_d[LINE_IDX_W'(n_q) + LINE_IDX_W'(k)] = 1'b1;
                    w_row_cnt = w_row_cnt + 4'd1;
                  end
                end else if (DIM_W'(k) < n_q) begin
                  dirty_d[k] = 1'b1;
                end
              end
            end
            w_known_sum = {1'b0, known_q} + (CELL_CNT_W + 1)'(w_row_cnt);
            known_d     = w_known_sum[CELL_CNT_W] ? '1 : w_known_sum[CELL_CNT_W-1:0];
            ptr_d       = (w_cur_inc == w_len) ? '0 : w_cur_inc;
            state_d     = SCAN;
          end
        end
      end

      FINISH: begin
        solved_d = !error_q && (8'(known_q) == w_nm);
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q  <= IDLE;
      dirty_q  <= '0;
      ptr_q    <= '0;
      cur_q    <= '0;
      known_q  <= '0;
      pass_q   <= '0;
      n_q      <= '0;
      m_q      <= '0;
      solved_q <= 1'b0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dirty_q  <= dirty_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      known_q  <= known_d;
      pass_q   <= pass_d;
      n_q      <= n_d;
      m_q      <= m_d;
      solved_q <= solved_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_line_scheduler : directed scoreboard bench for line_scheduler           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_line_scheduler;
  import nonogram_pkg::*;

  logic                  clk_100mhz = 1'b0;
  logic                  rst;
  logic                  start_i;
  logic [DIM_W-1:0]      n_i;
  logic [DIM_W-1:0]      m_i;
  logic                  dispatch_valid_o;
  logic                  dispatch_ready_i;
  logic [LINE_IDX_W-1:0] dispatch_idx_o;
  logic                  result_valid_i;
  logic [MAX_DIM-1:0]    result_new_mask_i;
  logic                  result_conflict_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  solved_o;
  logic                  error_o;
  logic [15:0]           pass_count_o;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned exp_q[$];

  always #5 clk_100mhz = ~clk_100mhz;

  line_scheduler dut (
    .clk_100mhz        (clk_100mhz),
    .rst               (rst),
    .start_i           (start_i),
    .n_i               (n_i),
    .m_i               (m_i),
    .dispatch_valid_o  (dispatch_valid_o),
    .dispatch_ready_i  (dispatch_ready_i),
    .dispatch_idx_o    (dispatch_idx_o),
    .result_valid_i    (result_valid_i),
    .result_new_mask_i (result_new_mask_i),
    .result_conflict_i (result_conflict_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .solved_o          (solved_o),
    .error_o           (error_o),
    .pass_count_o      (pass_count_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_100mhz);
  endtask

  task automatic do_start(input logic [3:0] nn, input logic [3:0] mm);
    start_i = 1'b1;
    n_i     = nn;
    m_i     = mm;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_dispatch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dispatch_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Act as the line solver for one dispatched line.
  task automatic serve(input logic [MAX_DIM-1:0] mask, input logic conflict);
    bit          ok;
    int unsigned e;
    wait_dispatch(ok);
    chk("dispatch_seen", 32'(ok), 32'd1);
    if (ok) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
      chk("dispatch_idx", 32'(dispatch_idx_o), e);
      dispatch_ready_i = 1'b1;
      tick();
      dispatch_ready_i = 1'b0;
      chk("valid_after_hs", 32'(dispatch_valid_o), 32'd0);
      tick();
      tick();
      result_valid_i    = 1'b1;
      result_new_mask_i = mask;
      result_conflict_i = conflict;
      tick();
      result_valid_i    = 1'b0;
      result_new_mask_i = '0;
      result_conflict_i = 1'b0;
    end
  endtask

  task automatic wait_done(input logic exp_solved, input logic exp_error, input logic [15:0] exp_pass);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("solved", 32'(solved_o), 32'(exp_solved));
    chk("error", 32'(error_o), 32'(exp_error));
    chk("pass_count", 32'(pass_count_o), 32'(exp_pass));
    chk("busy_at_done", 32'(busy_o), 32'd0);
    tick();
    chk("done_pulse", 32'(done_o), 32'd0);
    chk("no_dispatch_after", 32'(dispatch_valid_o), 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    bit ok;
    rst               = 1'b1;
    start_i           = 1'b0;
    n_i               = '0;
    m_i               = '0;
    dispatch_ready_i  = 1'b0;
    result_valid_i    = 1'b0;
    result_new_mask_i = '0;
    result_conflict_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_solved", 32'(solved_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_valid", 32'(dispatch_valid_o), 32'd0);
    chk("rst_pass", 32'(pass_count_o), 32'd0);

    // 1x1: row 0 determines its cell, column 1 gets dirtied again.
    do_start(4'd1, 4'd1);
    chk("busy_after_start", 32'(busy_o), 32'd1);
    exp_q.push_back(0);
    exp_q.push_back(1);
    serve(11'h001, 1'b0);
    serve(11'h000, 1'b0);
    wait_done(1'b1, 1'b0, 16'd2);

    // 2x3 with back-pressure, then a conflict ends it.
    do_start(4'd2, 4'd3);
    exp_q.push_back(0);
    wait_dispatch(ok);
    chk("bp_dispatch_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", 32'(dispatch_valid_o), 32'd1);
      chk("bp_idx_held", 32'(dispatch_idx_o), 32'd0);
      tick();
    end
    serve(11'h000, 1'b1);
    wait_done(1'b0, 1'b1, 16'd1);

    // 11x11: every row fully determined, columns add nothing.
    do_start(4'd11, 4'd11);
    for (int i = 0; i < 22; i++) exp_q.push_back(i);
    for (int i = 0; i < 22; i++) serve((i < 11) ? 11'h7FF : 11'h000, 1'b0);
    wait_done(1'b1, 1'b0, 16'd22);

    // 3x3, nothing learned: stuck.
    do_start(4'd3, 4'd3);
    for (int i = 0; i < 6; i++) exp_q.push_back(i);
    for (int i = 0; i < 6; i++) serve(11'h000, 1'b0);
    wait_done(1'b0, 1'b0, 16'd6);

    // 2x2, row 1 conflicts.
    do_start(4'd2, 4'd2);
    exp_q.push_back(0);
    exp_q.push_back(1);
    serve(11'h000, 1'b0);
    serve(11'h000, 1'b1);
    wait_done(1'b0, 1'b1, 16'd2);

    // 2x2: column re-dirties rows, wrap-around, out-of-range row bits ignored.
    do_start(4'd2, 4'd2);
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    serve(11'h000, 1'b0);
    serve(11'h000, 1'b0);
    serve(11'h003, 1'b0);
    serve(11'h000, 1'b0);
    serve(11'h7FF, 1'b0);
    serve(11'h003, 1'b0);
    serve(11'h000, 1'b0);
    serve(11'h000, 1'b0);
    wait_done(1'b1, 1'b0, 16'd8);

    // Illegal dimensions.
    do_start(4'd12, 4'd3);
    chk("bad_n_done", 32'(done_o), 32'd1);
    chk("bad_n_error", 32'(error_o), 32'd1);
    chk("bad_n_busy", 32'(busy_o), 32'd0);
    tick();
    chk("bad_n_done_pulse", 32'(done_o), 32'd0);
    chk("bad_n_error_held", 32'(error_o), 32'd1);
    chk("bad_n_no_dispatch", 32'(dispatch_valid_o), 32'd0);
    do_start(4'd3, 4'd0);
    chk("bad_m_done", 32'(done_o), 32'd1);
    chk("bad_m_error", 32'(error_o), 32'd1);
    tick();

    // Reset while waiting on the solver.
    do_start(4'd2, 4'd2);
    chk("restart_error_clr", 32'(error_o), 32'd0);
    exp_q.push_back(0);
    wait_dispatch(ok);
    chk("rst_case_dispatch", 32'(ok), 32'd1);
    chk("rst_case_idx", 32'(dispatch_idx_o), exp_q.pop_front());
    dispatch_ready_i = 1'b1;
    tick();
    dispatch_ready_i = 1'b0;
    chk("wait_busy", 32'(busy_o), 32'd1);
    chk("wait_pass", 32'(pass_count_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_pass", 32'(pass_count_o), 32'd0);
    chk("mid_rst_valid", 32'(dispatch_valid_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    result_valid_i    = 1'b1;
    result_new_mask_i = 11'h001;
    tick();
    result_valid_i    = 1'b0;
    result_new_mask_i = '0;
    chk("stray_result_idle", 32'(busy_o), 32'd0);

    // Fresh run after reset.
    do_start(4'd1, 4'd1);
    exp_q.push_back(0);
    exp_q.push_back(1);
    serve(11'h001, 1'b0);
    serve(11'h000, 1'b0);
    wait_done(1'b1, 1'b0, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
